pwm_peripheral: RTL



---
 rtl/pwm_pkg.sv | 10 +
 rtl/pwm_tick_gen.sv | 26 ++
 rtl/pwm_peripheral.sv | 68 ++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the 16-pin PWM peripheral.
// The counter runs 0..PWM_LAST, so a period is 255 steps.
package pwm_pkg;

    localparam int unsigned NUM_CH           = 16;
    localparam logic [7:0]  PWM_LAST         = 8'd254;
    localparam logic [7:0]  DUTY_FULL        = 8'hFF;
    localparam int unsigned DEFAULT_TICK_DIV = 13;

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: asserts tick for one clk every TICK_DIV clocks (every clock when TICK_DIV is 1).
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    logic [15:0] tick_cnt;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 pins as forced-low, static-high or a shared 8-bit PWM waveform.
// Duty changes go through a shadow register loaded only at the period wrap.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] en_reg_out_7_0,
    input  logic [7:0] en_reg_out_15_8,
    input  logic [7:0] en_reg_pwm_7_0,
    input  logic [7:0] en_reg_pwm_15_8,
    input  logic [7:0] pwm_duty_cycle,
    output logic [7:0] out_7_0,
    output logic [7:0] out_15_8,
    output logic       period_start
);

    logic              tick;
    logic              wrap;
    logic              pwm_level;
    logic [7:0]        pwm_cnt;
    logic [7:0]        duty_shadow;
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
    logic [NUM_CH-1:0] pin_next;
    logic [NUM_CH-1:0] pins;

    pwm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign wrap   = tick && (pwm_cnt == PWM_LAST);

    // Full scale is special-cased: pwm_cnt never reaches 255, so it would otherwise still be all-high,
    // but the explicit term keeps the intent obvious.
    assign pwm_level = (duty_shadow == DUTY_FULL) || (pwm_cnt < duty_shadow);
    assign pin_next  = en_out & (~en_pwm | {NUM_CH{pwm_level}});

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt      <= '0;
            duty_shadow  <= '0;
            period_start <= 1'b0;
            pins         <= '0;
        end else begin
            period_start <= wrap;
            pins         <= pin_next;
            if (tick) begin
                pwm_cnt <= wrap ? 8'd0 : pwm_cnt + 8'd1;
            end
            if (wrap) begin
                duty_shadow <= pwm_duty_cycle;
            end
        end
    end

    assign out_7_0  = pins[7:0];
    assign out_15_8 = pins[15:8];

endmodule
